// File: rtl/dp_unit_if.sv
// Operand/result bus for dp_unit: enable, packed operand vectors, 2-bit beat
// control, and the accumulator result with its update strobe.
interface dp_unit_if #(
  parameter int N_MUL  = 4,
  parameter int DW_MUL = 8,
  parameter int DW_ADD = 32
);
  logic                      enable;
  logic [N_MUL*DW_MUL-1:0]   in_a;
  logic [N_MUL*DW_MUL-1:0]   in_b;
  logic [1:0]                in_valid;
  logic signed [DW_ADD-1:0]  out;
  logic                      out_valid;

  modport master (output enable, in_a, in_b, in_valid, input out, out_valid);
  modport slave  (input enable, in_a, in_b, in_valid, output out, out_valid);
endinterface

// File: rtl/dp_unit.sv
// dp_unit: signed dot-product / multiply-accumulate processing element.
//   S1: per-lane signed products, S2: adder-tree sum, S3: accumulator -> out.
//   Beat control in_valid: 11 load, 01 accumulate, 10 clear, 00 idle.
//   enable=0 freezes every register; inputs on that edge are dropped.
// Build option: define DP_UNIT_SATURATE_EN to clamp the S3 result to the
// signed DW_ADD range instead of wrapping modulo 2^DW_ADD.

// One multiplier lane: registered signed product of an element pair.
module dp_mul_lane #(
  parameter int DW_MUL = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic signed [DW_MUL-1:0]   a,
  input  logic signed [DW_MUL-1:0]   b,
  output logic signed [2*DW_MUL-1:0] prod
);
  // S1 product register, advances only with enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      prod <= '0;
    else if (enable) prod <= a * b;
  end
endmodule

module dp_unit #(
  parameter int N_MUL  = 4,
  parameter int DW_MUL = 8,
  parameter int DW_ADD = 32
) (
  input  logic     clk,
  input  logic     reset,
  dp_unit_if.slave bus
);
  localparam int STAGES = 2;  // control travels with data through S1, S2

  logic signed [2*DW_MUL-1:0] prod [N_MUL];
  logic [STAGES:1][1:0]       vld_pipe;
  logic signed [DW_ADD-1:0]   tree_sum;
  logic signed [DW_ADD-1:0]   ext;
  logic signed [DW_ADD-1:0]   sum_q;
  logic signed [DW_ADD-1:0]   acc_nxt;

  // Add two accumulator-width values, wrapping or clamping per build option.
  function automatic logic signed [DW_ADD-1:0] add_fit(
    input logic signed [DW_ADD-1:0] x,
    input logic signed [DW_ADD-1:0] y
  );
`ifdef DP_UNIT_SATURATE_EN
    logic signed [DW_ADD:0] wide;
    wide = {x[DW_ADD-1], x} + {y[DW_ADD-1], y};
    // Sign bit disagreeing with the guard bit means the true sum left range
    if (wide[DW_ADD] != wide[DW_ADD-1])
      add_fit = wide[DW_ADD] ? {1'b1, {(DW_ADD-1){1'b0}}}
                             : {1'b0, {(DW_ADD-1){1'b1}}};
    else
      add_fit = wide[DW_ADD-1:0];
`else
    add_fit = x + y;
`endif
  endfunction

  for (genvar i = 0; i < N_MUL; i++) begin : g_lane
    dp_mul_lane #(.DW_MUL(DW_MUL)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .enable (bus.enable),
      .a      (bus.in_a[i*DW_MUL +: DW_MUL]),
      .b      (bus.in_b[i*DW_MUL +: DW_MUL]),
      .prod   (prod[i])
    );
  end

  // Beat control shift register, aligned with the data stages
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          vld_pipe <= '0;
    else if (bus.enable) vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_valid};
  end

  // Adder tree over sign-extended products; width rule means no overflow here
  always_comb begin
    tree_sum = '0;
    ext      = '0;
    for (int i = 0; i < N_MUL; i++) begin
      ext      = prod[i];
      tree_sum = tree_sum + ext;
    end
  end

  // S2 sum register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          sum_q <= '0;
    else if (bus.enable) sum_q <= tree_sum;
  end

  // Next accumulator value from the S2 beat control
  always_comb begin
    acc_nxt = bus.out;
    case (vld_pipe[STAGES])
      2'b11:   acc_nxt = add_fit('0, sum_q);
      2'b01:   acc_nxt = add_fit(bus.out, sum_q);
      2'b10:   acc_nxt = '0;
      default: acc_nxt = bus.out;
    endcase
  end

  // S3 accumulator doubles as the output register; strobe on non-idle beats
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
    end else if (bus.enable) begin
      bus.out       <= acc_nxt;
      bus.out_valid <= (vld_pipe[STAGES] != 2'b00);
    end
  end
endmodule

// File: tb/tb_dp_unit.sv
// Bench for dp_unit: a 32-bit accumulator instance and an 18-bit one (for
// overflow) share stimulus. A queue-based model predicts every cycle; literal
// values pin the model on the directed vectors.
module tb_dp_unit;
  localparam int NM = 4;
  localparam int DM = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dp_unit_if #(.N_MUL(NM), .DW_MUL(DM), .DW_ADD(32)) bus_w ();
  dp_unit_if #(.N_MUL(NM), .DW_MUL(DM), .DW_ADD(18)) bus_n ();

  dp_unit #(.N_MUL(NM), .DW_MUL(DM), .DW_ADD(32)) u_dut (
    .clk(clk), .reset(reset), .bus(bus_w));
  dp_unit #(.N_MUL(NM), .DW_MUL(DM), .DW_ADD(18)) u_ovf (
    .clk(clk), .reset(reset), .bus(bus_n));

  int checks = 0;
  int errors = 0;
  bit done = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NM*DM-1:0] pk(input int e0, input int e1,
                                          input int e2, input int e3);
    logic [DM-1:0] v0, v1, v2, v3;
    v0 = DM'(e0); v1 = DM'(e1); v2 = DM'(e2); v3 = DM'(e3);
    return {v3, v2, v1, v0};
  endfunction

  // ---------------- model ----------------
  typedef struct { logic [1:0] ctl; longint dot; } beat_t;
  beat_t  pend[$];
  longint macc [2];
  bit     mvld;
  int     width [2] = '{32, 18};

  function automatic longint dotp(input logic [NM*DM-1:0] a,
                                  input logic [NM*DM-1:0] b);
    longint s = 0;
    logic signed [DM-1:0] ea, eb;
    for (int i = 0; i < NM; i++) begin
      ea = a[i*DM +: DM];
      eb = b[i*DM +: DM];
      s += longint'(ea) * longint'(eb);
    end
    return s;
  endfunction

  function automatic longint fit(input longint v, input int w);
    longint lim = longint'(1) << (w - 1);
    longint r;
`ifdef DP_UNIT_SATURATE_EN
    r = (v > lim - 1) ? lim - 1 : (v < -lim) ? -lim : v;
`else
    r = v & ((lim << 1) - 1);
    if (r >= lim) r -= (lim << 1);
`endif
    return r;
  endfunction

  initial begin
    beat_t b;
    macc = '{0, 0};
    mvld = 0;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        pend.delete();
        macc = '{0, 0};
        mvld = 0;
      end else if (bus_w.enable) begin
        mvld = 0;
        if (pend.size() == 2) begin
          b = pend.pop_front();
          mvld = (b.ctl != 2'b00);
          for (int k = 0; k < 2; k++)
            case (b.ctl)
              2'b11: macc[k] = fit(b.dot, width[k]);
              2'b01: macc[k] = fit(macc[k] + b.dot, width[k]);
              2'b10: macc[k] = 0;
              default: ;
            endcase
        end
        pend.push_back('{bus_w.in_valid, dotp(bus_w.in_a, bus_w.in_b)});
      end
    end
  end

  // Cycle-by-cycle comparison away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (!done) begin
        chk("out32", bus_w.out, macc[0]);
        chk("vld32", longint'(bus_w.out_valid), longint'(mvld));
        chk("out18", bus_n.out, macc[1]);
        chk("vld18", longint'(bus_n.out_valid), longint'(mvld));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic en, input logic [1:0] ctl,
                       input logic [NM*DM-1:0] a, input logic [NM*DM-1:0] b);
    bus_w.enable = en;  bus_n.enable = en;
    bus_w.in_valid = ctl; bus_n.in_valid = ctl;
    bus_w.in_a = a; bus_n.in_a = a;
    bus_w.in_b = b; bus_n.in_b = b;
  endtask

  // At the next falling edge optionally pin out32, then present a beat
  task automatic step(input string name, input bit ce, input longint cv,
                      input logic [1:0] ctl, input logic [NM*DM-1:0] a,
                      input logic [NM*DM-1:0] b);
    @(negedge clk);
    if (ce) chk(name, bus_w.out, cv);
    drive(1'b1, ctl, a, b);
  endtask

  task automatic idle(input string name, input bit ce, input longint cv);
    step(name, ce, cv, 2'b00, '0, '0);
  endtask

  logic [NM*DM-1:0] z;
  initial begin
    z = '0;
    drive(1'b1, 2'b00, '0, '0);
    #2;
    chk("rst_out", bus_w.out, 0);
    chk("rst_vld", longint'(bus_w.out_valid), 0);
    @(negedge clk); reset = 1'b1;

    // load / clear / acc / idle sequence
    step("seq0", 0, 0, 2'b11, pk(2,2,2,2), pk(-2,-2,-2,-2));
    step("seq1", 0, 0, 2'b10, pk(9,9,9,9), pk(9,9,9,9));
    step("seq2", 0, 0, 2'b01, pk(1,1,1,1), pk(1,1,1,1));
    step("seq_load", 1, -16, 2'b00, pk(2,2,2,2), pk(2,2,2,2));
    idle("seq_clear", 1, 0);
    idle("seq_acc", 1, 4);
    idle("seq_idle", 1, 4);

    // streaming accumulate
    step("st0", 0, 0, 2'b11, pk(1,1,1,1), pk(3,3,3,3));
    step("st1", 0, 0, 2'b01, pk(1,1,1,1), pk(3,3,3,3));
    step("st2", 0, 0, 2'b01, pk(1,1,1,1), pk(3,3,3,3));
    step("st_12", 1, 12, 2'b01, pk(1,1,1,1), pk(3,3,3,3));
    idle("st_24", 1, 24);
    idle("st_36", 1, 36);
    idle("st_48", 1, 48);

    // extremes and a mixed-sign vector
    step("ex0", 0, 0, 2'b11, pk(-128,-128,-128,-128), pk(-128,-128,-128,-128));
    step("ex1", 0, 0, 2'b11, pk(-128,-128,-128,-128), pk(127,127,127,127));
    step("ex2", 0, 0, 2'b11, pk(1,-2,3,-4), pk(5,6,-7,8));
    idle("ex_max", 1, 65536);
    idle("ex_min", 1, -65024);
    idle("ex_mix", 1, -60);

    // stall between two ACC beats, with junk presented while stalled
    step("sl0", 0, 0, 2'b11, pk(1,1,1,1), pk(1,1,1,1));
    repeat (3) begin
      @(negedge clk);
      drive(1'b0, 2'b01, pk(50,50,50,50), pk(50,50,50,50));
    end
    step("sl1", 0, 0, 2'b01, pk(1,1,1,1), pk(2,2,2,2));
    idle("sl2", 0, 0);
    idle("sl_load", 1, 4);
    idle("sl_sum", 1, 12);

    // overflow on the 18-bit instance
    step("ov0", 0, 0, 2'b11, pk(-128,-128,-128,-128), pk(-128,-128,-128,-128));
    step("ov1", 0, 0, 2'b01, pk(-128,-128,-128,-128), pk(-128,-128,-128,-128));
    idle("ov2", 0, 0);
    idle("ov3", 0, 0);
    @(negedge clk);
    chk("ov32", bus_w.out, 131072);
`ifdef DP_UNIT_SATURATE_EN
    chk("ov18", bus_n.out, 131071);
`else
    chk("ov18", bus_n.out, -131072);
`endif

    // asynchronous reset mid-stream with beats in flight
    step("rs0", 0, 0, 2'b11, pk(3,3,3,3), pk(3,3,3,3));
    step("rs1", 0, 0, 2'b01, pk(3,3,3,3), pk(3,3,3,3));
    #2 reset = 1'b0;
    #1;
    chk("async_out", bus_w.out, 0);
    chk("async_vld", longint'(bus_w.out_valid), 0);
    chk("async_out18", bus_n.out, 0);
    drive(1'b1, 2'b00, z, z);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    step("rs2", 0, 0, 2'b01, pk(1,1,1,1), pk(1,1,1,1));
    idle("rs3", 0, 0);
    idle("rs4", 0, 0);
    idle("rs_fresh", 1, 4);
    idle("rs_end", 1, 4);

    @(negedge clk);
    done = 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dp_unit.md
Name: dp_unit

Overview:
- Signed integer dot-product / multiply-accumulate unit: N_MUL parallel DW_MUL-bit multipliers feed an adder tree into a DW_ADD-bit accumulator.
- Used as the processing element inside the tensor-core datapath.
- Operand vectors are packed flat buses.
- A 2-bit per-beat control selects load, clear, accumulate or idle.

Parameters:
- N_MUL, 4, number of element pairs per beat (>=1; need not be a power of 2).
- DW_MUL, 8, width of each signed element of in_a/in_b.
- DW_ADD, 32, accumulator/output width; must be >= 2*DW_MUL + ceil(log2(N_MUL)).

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- reset  input  1  asynchronous, active-low reset (reset=0 resets; named "reset" per codebase).
- enable  input  1  pipeline advance; 0 = every stage holds its state.
- in_a  input  N_MUL*DW_MUL  packed signed elements; element i = bits [i*DW_MUL +: DW_MUL].
- in_b  input  N_MUL*DW_MUL  packed signed elements, same layout.
- in_valid  input  2  [1]=init, [0]=data valid (encoding below).
- out  output  DW_ADD  signed accumulator value.
- out_valid  output  1  pulses 1 cycle when out was updated by a beat with in_valid!=00.

Behaviour:
- Reset (asynchronous, active-low): all pipeline registers, accumulator, out and out_valid = 0 immediately; held while reset=0.
- in_valid encoding, sampled per beat with the operands:
  - 11 LOAD: acc <= dot(a,b).
  - 01 ACC: acc <= acc + dot(a,b).
  - 10 CLEAR: acc <= 0; operands ignored.
  - 00 IDLE: acc holds.
- dot(a,b) = sum over i of a_i*b_i:
  - a_i, b_i are two's complement.
  - Each product is 2*DW_MUL bits signed.
  - The sum is sign-extended to DW_ADD before accumulation.
- Pipeline, each stage advancing only when enable=1:
  - S1: register the N_MUL products plus in_valid.
  - S2: register the adder-tree sum plus in_valid.
  - S3: accumulator update, registered to out.
- Latency: a beat sampled on edge k affects out after edge k+2 (3 registered stages). Throughput is 1 beat/cycle.
- enable=0:
  - No register changes, including out and out_valid.
  - Inputs presented on that edge are not captured.
  - Resuming continues exactly where the pipeline stalled.
- Back-to-back ACC beats each add in order; no bubbles required.
- out_valid=1 on the cycle following an S3 update whose control was not 00.
- Overflow: accumulator wraps modulo 2^DW_ADD in the default build.
- Reset asserted mid-stream discards every in-flight beat. After release, the first beat starts from acc=0.
- No backpressure and no handshake beyond enable; every beat is accepted when enable=1.

Optional Feature:
- Macro DP_UNIT_SATURATE_EN.
- When defined: the S3 add/load saturates to the signed DW_ADD range (max 2^(DW_ADD-1)-1, min -2^(DW_ADD-1)) instead of wrapping.
- When undefined: two's-complement wrap.
- Stages S1/S2 are unaffected; the tree cannot overflow, given the DW_ADD constraint.

Test Plan:
- Reset/idle: assert reset=0 mid-simulation with non-zero acc -> out=0 and out_valid=0 immediately, without waiting for a clock edge.
- Sequence (enable=1), each beat presented for one cycle:
  - Beat 1: in_valid=11, a={2,2,2,2}, b={-2,-2,-2,-2} -> out=-16.
  - Beat 2: in_valid=10 -> out=0.
  - Beat 3: in_valid=01, a=b={1,1,1,1} -> out=4.
  - Beat 4: in_valid=00, a=b={2,2,2,2} -> out holds 4.
  - Each result appears 3 edges after its beat.
- Streaming accumulate: LOAD {1,1,1,1}·{3,3,3,3}, then 3 consecutive ACC beats of the same operands -> out=12,24,36,48 on consecutive cycles; out_valid high 4 cycles.
- Extremes: a=b={-128 x4} LOAD -> out=65536; a={-128 x4}, b={127 x4} -> out=-65024.
- Stall: drop enable for 3 cycles between two ACC beats -> out frozen during stall; final sum identical to the unstalled run.
- Overflow with DW_ADD=18 and repeated ACC of 65536:
  - Default build wraps to -131072 after 2 beats.
  - With DP_UNIT_SATURATE_EN, out clamps at 131071.
